modulo_reabastecimento_rolhas: RTL
==================================

// Module: modulo_reabastecimento_rolhas
// PURPOSE
//   Cork reservoir controller, the counterpart of the minimum-cork detector.
//   - Holds the cork count consumed by the capping stage.
//   - Decrements the count per capped bottle.
//   - When the count reaches the minimum level, runs a 4-phase req/ack handshake
//     with the external cork dispenser and adds one batch per acknowledge until full.
//   - Sits between the capping FSM (cork_take) and the dispenser (refill_req/refill_ack).
// PARAMETERS
//   WIDTH      5     count width; all levels must fit in WIDTH bits
//   MIN_LEVEL  5     min_signal and refill start when count <= MIN_LEVEL
//   MAX_LEVEL  20    refill stops once count >= MAX_LEVEL; count saturates here
//   BATCH      5     corks added per dispenser acknowledge
//   TIMEOUT    15    max cycles in REQ without ack before fault (4-bit watchdog)
// PORTS
//   clk            in   1      system clock, rising edge
//   rst_n          in   1      asynchronous reset, active low
//   refill_en      in   1      enables automatic refill; 0 also clears fault
//   cork_take      in   1      1-cycle pulse: one cork consumed by the capper
//   refill_ack     in   1      dispenser acknowledge (4-phase, may be async-slow)
//   reg_r          out  WIDTH  current cork count
//   min_signal     out  1      count <= MIN_LEVEL (combinational from reg_r)
//   empty          out  1      reg_r == 0 (combinational)
//   refill_req     out  1      request to dispenser (registered)
//   busy           out  1      FSM not in IDLE (registered)
//   underflow_err  out  1      sticky: cork_take seen while empty
//   fault          out  1      dispenser watchdog expired (registered)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     reg_r=0, refill_req=0, busy=0, underflow_err=0, fault=0, state=IDLE, watchdog=0.
//     min_signal=1, empty=1.
//   Count update (every clk; sum computed at WIDTH+1 bits):
//     next = reg_r - take_ok + add_ok, then saturated to MAX_LEVEL.
//     take_ok = cork_take && reg_r != 0.
//     add_ok  = BATCH when the FSM is in REQ and samples refill_ack=1, else 0.
//     Simultaneous take and add: both apply in the same cycle,
//       e.g. 3 -> 3 + 5 - 1 = 7.
//     cork_take while reg_r == 0: count holds 0 and underflow_err sets (stays set until reset).
//   FSM states: IDLE, REQ, RELEASE, FAULT.
//     IDLE:
//       refill_en && reg_r <= MIN_LEVEL -> REQ, with refill_req=1 from the next cycle.
//     REQ:
//       refill_req=1; watchdog increments each cycle.
//       refill_ack=1 -> add BATCH, refill_req=0, watchdog=0 -> RELEASE.
//       watchdog == TIMEOUT with no ack -> FAULT, refill_req=0, fault=1.
//       refill_en=0 -> IDLE, refill_req=0 (abort is legal only before ack).
//     RELEASE:
//       refill_req=0; wait for refill_ack=0.
//       On ack low: count < MAX_LEVEL && refill_en -> REQ, else -> IDLE.
//       refill_en=0 does not abort this state; the handshake must complete.
//     FAULT:
//       fault=1, refill_req=0.
//       Leaves to IDLE, clearing fault, only when refill_en=0 is sampled.
//   Handshake rules:
//     - refill_req never rises while refill_ack=1.
//     - Exactly one batch is added per ack high-phase, however long ack stays high.
//   Latency: refill_req rises 1 cycle after the count reaches MIN_LEVEL; the count
//     increments on the same edge that samples ack in REQ.
//   Saturation: count 18 + BATCH 5 -> 20, not 23; the FSM then returns to IDLE.
//   Reset mid-handshake: everything returns to reset values immediately;
//     refill_req drops asynchronously.
// TESTING
//   1 Reset, refill_en=1, dispenser acks 2 cycles after each req
//     -> batches 0->5->10->15->20, then IDLE with refill_req=0 and min_signal=0.
//   2 Count 20, issue 15 cork_take pulses
//     -> count 5, min_signal=1, refill_req=1 one cycle later.
//   3 Count 3 in REQ, cork_take coincides with ack=1 -> count 7.
//   4 Count 0, cork_take pulse -> count stays 0, underflow_err=1, held until rst_n.
//   5 No ack for 15 REQ cycles -> fault=1, refill_req=0; drop refill_en -> fault=0, IDLE.
//   6 Hold ack high for 10 cycles in RELEASE -> only +5 added, no new req until ack=0.

Source files
------------

// File: rtl/modulo_reabastecimento_rolhas.sv
// Cork reservoir controller: tracks the cork count used by the capper and refills it
// from an external dispenser through a 4-phase req/ack handshake with a watchdog.
module modulo_reabastecimento_rolhas #(
    parameter int WIDTH     = 5,
    parameter int MIN_LEVEL = 5,
    parameter int MAX_LEVEL = 20,
    parameter int BATCH     = 5,
    parameter int TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refill_en,
    input  logic             cork_take,
    input  logic             refill_ack,
    output logic [WIDTH-1:0] reg_r,
    output logic             min_signal,
    output logic             empty,
    output logic             refill_req,
    output logic             busy,
    output logic             underflow_err,
    output logic             fault
);

    typedef enum logic [1:0] {IDLE, REQ, RELEASE, FAULT} state_e;

    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_LEVEL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_LEVEL);
    localparam logic [WIDTH:0]   MAX_W1  = (WIDTH+1)'(MAX_LEVEL);
    localparam logic [WIDTH:0]   BATCH_W = (WIDTH+1)'(BATCH);
    localparam logic [3:0]       TIMEOUT_W = 4'(TIMEOUT);

    state_e           state_q, state_d;
    logic [3:0]       wdog_q, wdog_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             refill_req_q, refill_req_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic             underflow_q, underflow_d;

    logic             take_ok;
    logic             add_ok;
    logic [WIDTH:0]   sum;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wdog_q       <= '0;
            count_q      <= '0;
            refill_req_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            count_q      <= count_d;
            refill_req_q <= refill_req_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            underflow_q  <= underflow_d;
        end
    end

    // Count datapath: take and batch add may land on the same edge.
    always_comb begin
        take_ok     = cork_take && (count_q != '0);
        add_ok      = (state_q == REQ) && refill_ack;
        sum         = {1'b0, count_q} - {{WIDTH{1'b0}}, take_ok} + (add_ok ? BATCH_W : '0);
        count_d     = (sum > MAX_W1) ? MAX_W : sum[WIDTH-1:0];
        underflow_d = underflow_q || (cork_take && (count_q == '0));
    end

    // NOTE: defaults first so every path assigns state_d/wdog_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (refill_en && (count_q <= MIN_W) && !refill_ack) state_d = REQ;
            end
            REQ: begin
                // An ack wins over a same-cycle abort: the batch is already delivered.
                if (refill_ack) begin
                    state_d = RELEASE;
                    wdog_d  = '0;
                end else if (!refill_en) begin
                    state_d = IDLE;
                    wdog_d  = '0;
                end else if (wdog_q + 4'd1 == TIMEOUT_W) begin
                    state_d = FAULT;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + 4'd1;
                end
            end
            RELEASE: begin
                if (!refill_ack) begin
                    state_d = (refill_en && (count_q < MAX_W)) ? REQ : IDLE;
                end
            end
            FAULT: begin
                if (!refill_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        refill_req_d = (state_d == REQ);
        busy_d       = (state_d != IDLE);
        fault_d      = (state_d == FAULT);
    end

    assign reg_r         = count_q;
    assign min_signal    = (count_q <= MIN_W);
    assign empty         = (count_q == '0);
    assign refill_req    = refill_req_q;
    assign busy          = busy_q;
    assign fault         = fault_q;
    assign underflow_err = underflow_q;

endmodule
